// File: rtl/hier_seq_node.sv
// hier_seq_node: hierarchy node that sequences NUM_CHILDREN child channels,
// either one after another (i_mode=0) or all at once (i_mode=1). Children
// are launched with one-cycle start pulses; their one-cycle done pulses are
// collected, and the node reports busy, a done pulse, errors and a run count.
//
// Optional feature: define HIER_SEQ_NODE_TIMEOUT_EN to build a per-WAIT
// timer that declares a child hung after CHILD_TIMEOUT cycles.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_start        run request, sampled only in IDLE
//   i_mode         0 = sequential, 1 = parallel, latched on accepted start
//   o_child_start  one-cycle launch pulses, one bit per child
//   i_child_done   one-cycle completion pulses, one bit per child
//   o_busy         high from LAUNCH through FIN
//   o_done         one-cycle pulse in FIN
//   o_err          at least one child timed out in the last run
//   o_err_mask     children that timed out in the last run
//   o_run_count    completed runs, wrapping
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start
// LAUNCH  | one cycle: pulse child_start (current child or all children)
// WAIT    | collect done pulses (and count timeout cycles if enabled)
// FIN     | one cycle: done pulse, run_count increment
module hier_seq_node #(
    parameter int NUM_CHILDREN  = 5,
    parameter int CHILD_TIMEOUT = 200,
    parameter int CNT_W         = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_mode,
    output logic [NUM_CHILDREN-1:0] o_child_start,
    input  logic [NUM_CHILDREN-1:0] i_child_done,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [NUM_CHILDREN-1:0] o_err_mask,
    output logic [CNT_W-1:0]        o_run_count
);

    localparam int IDX_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CHILDREN - 1);
    localparam logic [NUM_CHILDREN-1:0] ALL_ONES = '1;
    localparam logic [NUM_CHILDREN-1:0] ONE_HOT0 = NUM_CHILDREN'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    logic [1:0]              r_state;
    logic                    r_mode;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_CHILDREN-1:0] r_pending;
    logic [CNT_W-1:0]        r_run_count;

    logic                    w_seq_hit;
    logic [NUM_CHILDREN-1:0] w_pend_next;
    logic                    w_par_clear;
    logic                    w_timeout;

    assign w_seq_hit   = i_child_done[r_idx];
    assign w_pend_next = r_pending & ~i_child_done;
    assign w_par_clear = (w_pend_next == '0);

`ifdef HIER_SEQ_NODE_TIMEOUT_EN
    localparam int TMR_W = $clog2(CHILD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CHILD_TIMEOUT - 1);

    logic [TMR_W-1:0]        r_timer;
    logic                    r_err;
    logic [NUM_CHILDREN-1:0] r_err_mask;

    // Timer holds the number of WAIT cycles already elapsed, so the
    // CHILD_TIMEOUT-th WAIT cycle is the one seeing TMR_LAST.
    assign w_timeout = (r_state == S_WAIT) && (r_timer == TMR_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer    <= '0;
            r_err      <= 1'b0;
            r_err_mask <= '0;
        end else begin
            if (r_state == S_LAUNCH)
                r_timer <= '0;
            else if (r_state == S_WAIT)
                r_timer <= r_timer + TMR_W'(1);

            if (r_state == S_IDLE && i_start) begin
                r_err      <= 1'b0;
                r_err_mask <= '0;
            end else if (w_timeout) begin
                // A completion arriving on the last cycle wins over the timeout.
                if (!r_mode && !w_seq_hit) begin
                    r_err      <= 1'b1;
                    r_err_mask <= r_err_mask | (ONE_HOT0 << r_idx);
                end else if (r_mode && !w_par_clear) begin
                    r_err      <= 1'b1;
                    r_err_mask <= r_err_mask | w_pend_next;
                end
            end
        end
    end

    assign o_err      = r_err;
    assign o_err_mask = r_err_mask;
`else
    assign w_timeout  = 1'b0;
    assign o_err      = 1'b0;
    assign o_err_mask = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_idx       <= '0;
            r_pending   <= '0;
            r_run_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode  <= i_mode;
                        r_idx   <= '0;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (r_mode)
                        r_pending <= ALL_ONES;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!r_mode) begin
                        if (w_seq_hit || w_timeout) begin
                            if (r_idx == LAST_IDX) begin
                                r_state <= S_FIN;
                            end else begin
                                r_idx   <= r_idx + IDX_W'(1);
                                r_state <= S_LAUNCH;
                            end
                        end
                    end else begin
                        r_pending <= w_pend_next;
                        if (w_par_clear || w_timeout)
                            r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_run_count <= r_run_count + CNT_W'(1);
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_child_start = (r_state != S_LAUNCH) ? '0 :
                           (r_mode ? ALL_ONES : (ONE_HOT0 << r_idx));
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_FIN);
    assign o_run_count   = r_run_count;

endmodule

// File: tb/tb_hier_seq_node.sv
module tb_hier_seq_node;

    localparam int N  = 5;
    localparam int TO = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [N-1:0] child_start;
    logic [N-1:0] child_done;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] err_mask;
    logic [3:0]   run_count;

    logic [N-1:0] man_done;
    logic [N-1:0] resp_done;
    logic         resp_en;
    logic [N-1:0] resp_mute;
    int           cnt [N];

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] seen [$];
    int           done_cnt;
    int           cyc_to_done;
    logic [N-1:0] acc;

    always #5 clk = ~clk;

    assign child_done = man_done | resp_done;

    hier_seq_node #(
        .NUM_CHILDREN  (N),
        .CHILD_TIMEOUT (TO),
        .CNT_W         (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_mode        (mode),
        .o_child_start (child_start),
        .i_child_done  (child_done),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_err_mask    (err_mask),
        .o_run_count   (run_count)
    );

    // Child model: each launched child answers with a done pulse 3 cycles
    // after its start pulse, unless muted.
    initial begin
        resp_done = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                resp_done[i] = resp_en && (cnt[i] == 1);
                if (cnt[i] > 0) cnt[i]--;
                if (rst) cnt[i] = 0;
                else if (resp_en && child_start[i] && !resp_mute[i]) cnt[i] = 3;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with start already driven high; cycle 1 is the
    // LAUNCH cycle of the first child. Stops at the FIN cycle, then runs
    // 'tail' extra cycles still counting done pulses.
    task automatic run_watch(input int budget, input bit hold, input int flip, input int tail);
        seen.delete();
        done_cnt    = 0;
        cyc_to_done = -1;
        for (int c = 1; c <= budget && cyc_to_done < 0; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) start = 1'b0;
            if (c == flip) mode = 1'b1;
            if (child_start != '0) seen.push_back(child_start);
            if (done) begin
                done_cnt++;
                cyc_to_done = c;
            end
        end
        chk("watch_done_seen", 32'(cyc_to_done > 0), 1);
        repeat (tail) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    task automatic chk_seq_order(input string tag);
        chk({tag, "_len"}, seen.size(), N);
        for (int i = 0; i < N; i++)
            chk({tag, "_order"}, (i < seen.size()) ? 32'(seen[i]) : 32'hx, 32'(1) << i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        man_done = '0; resp_en = 1'b0; resp_mute = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {done, err, child_start, err_mask, run_count}, 0);
        rst = 1'b0;

        // Sequential run, children answer after 3 cycles.
        resp_en = 1'b1; mode = 1'b0;
        @(negedge clk);
        chk("seq_idle_busy", busy, 0);
        start = 1'b1;
        run_watch(100, 1'b0, 0, 1);
        chk_seq_order("seq");
        chk("seq_latency", cyc_to_done, 21);
        chk("seq_done_cnt", done_cnt, 1);
        chk("seq_busy_after", busy, 0);
        chk("seq_run_count", run_count, 1);
        chk("seq_err", err, 0);

        // Parallel run with hand-driven done pulses.
        resp_en = 1'b0; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("par_launch", child_start, 5'b11111);
        chk("par_busy", busy, 1);
        man_done = 5'b11111;
        @(negedge clk);
        chk("par_one_cycle", child_start, 0);
        man_done = 5'b10100;
        @(negedge clk);
        man_done = 5'b00001;
        @(negedge clk);
        man_done = 5'b00110;
        @(negedge clk);
        chk("par_not_done", done, 0);
        man_done = 5'b01000;
        @(negedge clk);
        man_done = '0;
        chk("par_done", done, 1);
        @(negedge clk);
        chk("par_done_once", done, 0);
        chk("par_busy_after", busy, 0);
        chk("par_run_count", run_count, 2);

        // start held high through FIN; mode flipped mid-run.
        resp_en = 1'b1; mode = 1'b0; start = 1'b1;
        run_watch(100, 1'b1, 3, 0);
        chk_seq_order("hold");
        chk("hold_latency", cyc_to_done, 21);
        mode = 1'b0;
        @(negedge clk);
        chk("hold_idle_busy", busy, 0);
        chk("hold_run_count", run_count, 3);
        run_watch(100, 1'b0, 0, 1);
        chk_seq_order("hold2");
        chk("hold2_latency", cyc_to_done, 21);
        chk("hold2_run_count", run_count, 4);

        // Reset while waiting on child 2.
        start = 1'b1;
        for (int c = 1; c <= 40 && child_start != 5'b00100; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rstmid_reach_c2", child_start, 5'b00100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_outputs", {done, err, child_start, err_mask, run_count}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc = '0;
        repeat (10) begin
            @(negedge clk);
            acc = acc | child_start;
        end
        chk("rstmid_no_launch", acc, 0);
        start = 1'b1;
        run_watch(100, 1'b0, 0, 1);
        chk_seq_order("rstmid");
        chk("rstmid_run_count", run_count, 1);

        // run_count wrap over 16 back-to-back parallel runs.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode = 1'b1;
        for (int r = 0; r < 15; r++) begin
            start = 1'b1;
            run_watch(60, 1'b0, 0, 1);
        end
        chk("par_resp_latency", cyc_to_done, 5);
        chk("wrap_f", run_count, 4'hF);
        start = 1'b1;
        run_watch(60, 1'b0, 0, 1);
        chk("wrap_0", run_count, 4'h0);

`ifdef HIER_SEQ_NODE_TIMEOUT_EN
        // Child 3 hangs; timeout after 10 WAIT cycles, child 4 still runs.
        mode = 1'b0; resp_mute = 5'b01000; start = 1'b1;
        run_watch(100, 1'b0, 0, 1);
        chk_seq_order("to");
        chk("to_latency", cyc_to_done, 28);
        chk("to_done_cnt", done_cnt, 1);
        chk("to_err", err, 1);
        chk("to_err_mask", err_mask, 5'b01000);
        resp_mute = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_err_clear", err, 0);
        chk("to_mask_clear", err_mask, 0);
        cyc_to_done = -1;
        for (int c = 0; c < 60 && cyc_to_done < 0; c++) begin
            @(negedge clk);
            if (done) cyc_to_done = c;
        end
        chk("to_rerun_done", 32'(cyc_to_done >= 0), 1);
        chk("to_rerun_err", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
